// File: rtl/mcd212_pkg.sv
// Shared types and lane helpers for the MCD212 CPU-side bus master.
package mcd212_pkg;

   localparam int BUS_ADDR_W = 23;

   typedef enum logic [1:0] {
      OK         = 2'd0,
      MISALIGNED = 2'd1,
      TIMEOUT    = 2'd2
   } bus_status_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_RECOVER,
      S_RESP
   } bus_master_state_t;

   // {uds, lds}: uds is the even (upper) byte, lds the odd (lower) byte.
   function automatic logic [1:0] lane_strobes(input logic is_byte, input logic a0);
      return {(!is_byte || !a0), (!is_byte || a0)};
   endfunction

   // Byte writes take the lane picked by a0 and drive it on both halves of the bus.
   function automatic logic [15:0] write_lanes(input logic [15:0] wdata,
                                               input logic is_byte, input logic a0);
      logic [7:0] b;
      b = a0 ? wdata[7:0] : wdata[15:8];
      return is_byte ? {b, b} : wdata;
   endfunction

   // Byte reads are right-justified and zero-extended.
   function automatic logic [15:0] read_extract(input logic [15:0] din,
                                                input logic is_byte, input logic a0);
      if (!is_byte)
         return din;
      return a0 ? {8'h00, din[7:0]} : {8'h00, din[15:8]};
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/cpu_bus_master.sv
// Single-beat bus initiator for the MCD212 CPU-side bus: one request in flight,
// honours bus_ack wait states, times out, and idles the bus between accesses.
module cpu_bus_master
   import mcd212_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int IDLE_CYCLES    = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [BUS_ADDR_W-1:0] req_addr,
   input  logic                  req_write,
   input  logic                  req_byte,
   input  logic [15:0]           req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [15:0]           rsp_rdata,
   output logic [1:0]            rsp_status,
   output logic [21:0]           cpu_address,
   output logic [15:0]           cpu_dout,
   input  logic [15:0]           cpu_din,
   output logic                  cpu_uds,
   output logic                  cpu_lds,
   output logic                  cpu_write_strobe,
   output logic                  cs,
   input  logic                  cpu_bus_ack
);

   // Last count value of each timed state; the counter is 8 bits and saturates.
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);

   bus_master_state_t state;
   logic [7:0]        cnt;
   logic              write_q;
   logic              byte_q;
   logic              a0_q;

   // Bus cycle sequencer; every bus and response output is registered here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         cnt              <= '0;
         write_q          <= 1'b0;
         byte_q           <= 1'b0;
         a0_q             <= 1'b0;
         req_ready        <= 1'b1;
         rsp_valid        <= 1'b0;
         rsp_rdata        <= '0;
         rsp_status       <= OK;
         cpu_address      <= '0;
         cpu_dout         <= '0;
         cpu_uds          <= 1'b0;
         cpu_lds          <= 1'b0;
         cpu_write_strobe <= 1'b0;
         cs               <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  write_q   <= req_write;
                  byte_q    <= req_byte;
                  a0_q      <= req_addr[0];
                  cnt       <= '0;
                  req_ready <= 1'b0;
                  rsp_rdata <= '0;
                  if (!req_byte && req_addr[0]) begin
                     // Odd word address: answer at once, never touch the bus.
                     rsp_status <= MISALIGNED;
                     rsp_valid  <= 1'b1;
                     state      <= S_RESP;
                  end else begin
                     rsp_status           <= OK;
                     cs                   <= 1'b1;
                     cpu_address          <= req_addr[22:1];
                     {cpu_uds, cpu_lds}   <= lane_strobes(req_byte, req_addr[0]);
                     cpu_write_strobe     <= req_write;
                     cpu_dout             <= write_lanes(req_wdata, req_byte, req_addr[0]);
                     state                <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               // bus_ack is not meaningful yet: the responder registers its read data.
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (cpu_bus_ack || cnt >= TO_LAST) begin
                  if (!cpu_bus_ack) begin
                     rsp_status <= TIMEOUT;
                     rsp_rdata  <= '0;
                  end else if (!write_q) begin
                     rsp_rdata <= read_extract(cpu_din, byte_q, a0_q);
                  end
                  cs               <= 1'b0;
                  cpu_uds          <= 1'b0;
                  cpu_lds          <= 1'b0;
                  cpu_write_strobe <= 1'b0;
                  cnt              <= '0;
                  state            <= S_RECOVER;
               end else begin
                  cnt <= sat_inc8(cnt);
               end
            end
            S_RECOVER: begin
               // Quiet bus lets the responder clear its one-shot wait-state flag.
               if (cnt >= IDLE_LAST) begin
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  cnt <= sat_inc8(cnt);
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: MCD212-like responder (RAM with one read wait state,
// zero-wait channel status register, optional stuck bus_ack) and a byte-level
// reference memory that predicts every response.
module tb_cpu_bus_master;
   import mcd212_pkg::*;

   localparam int TO = 8;
   localparam int IC = 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [22:0] req_addr;
   logic        req_write;
   logic        req_byte;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic [21:0] cpu_address;
   logic [15:0] cpu_dout;
   logic [15:0] cpu_din;
   logic        cpu_uds;
   logic        cpu_lds;
   logic        cpu_write_strobe;
   logic        cs;
   logic        cpu_bus_ack;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cpu_bus_master #(.TIMEOUT_CYCLES(TO), .IDLE_CYCLES(IC)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_addr         (req_addr),
      .req_write        (req_write),
      .req_byte         (req_byte),
      .req_wdata        (req_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_rdata        (rsp_rdata),
      .rsp_status       (rsp_status),
      .cpu_address      (cpu_address),
      .cpu_dout         (cpu_dout),
      .cpu_din          (cpu_din),
      .cpu_uds          (cpu_uds),
      .cpu_lds          (cpu_lds),
      .cpu_write_strobe (cpu_write_strobe),
      .cs               (cs),
      .cpu_bus_ack      (cpu_bus_ack)
   );

   // ---------------- responder model ----------------
   logic [15:0] ram [0:1023];
   logic        ram_clr;
   logic        hang;
   logic [7:0]  stat_lo;
   logic [1:0]  cs_cnt;
   logic        is_stat_w;
   logic [9:0]  widx;

   assign is_stat_w = (cpu_address == 22'h27FFF8);
   assign widx      = cpu_address[9:0];
   assign cpu_din   = is_stat_w ? {8'h00, stat_lo} : ram[widx];

   always_comb begin
      cpu_bus_ack = 1'b1;
      if (hang)
         cpu_bus_ack = 1'b0;
      else if (!is_stat_w && !cpu_write_strobe)
         cpu_bus_ack = (cs_cnt >= 2'd2);
   end

   always @(posedge clk) begin
      if (!cs)
         cs_cnt <= 2'd0;
      else if (cs_cnt != 2'd3)
         cs_cnt <= cs_cnt + 2'd1;
   end

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 1024; i++)
            ram[i] <= 16'h0000;
      end else if (cs && cpu_write_strobe && cpu_bus_ack && !is_stat_w) begin
         if (cpu_uds) ram[widx][15:8] <= cpu_dout[15:8];
         if (cpu_lds) ram[widx][7:0]  <= cpu_dout[7:0];
      end
   end

   // ---------------- reference memory (byte addressed) ----------------
   logic [7:0] ref_mem [0:2047];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus cycles (cs high) an access should take, from the responder's wait rules.
   function automatic int exp_bus_cycles(input bit mis, input bit st, input bit wr, input bit hng);
      if (mis) return 0;
      if (hng) return 1 + TO;
      if (wr || st) return 2;
      return 3;
   endfunction

   task automatic txn(input string nm, input logic [22:0] a, input bit wr, input bit byt,
                      input logic [15:0] wd, input int hold);
      bit          mis, st;
      int          ecyc, idx, busy, ncs, nu, nl, nw;
      logic [15:0] erd, seen_dout;
      logic [1:0]  est;
      logic [7:0]  wb;
      logic [21:0] seen_addr;
      bit          first;
      mis  = !byt && a[0];
      st   = (a[22:1] == 22'h27FFF8);
      idx  = int'(a[10:0]);
      ecyc = exp_bus_cycles(mis, st, wr, hang);
      est  = mis ? 2'd1 : (hang ? 2'd2 : 2'd0);
      wb   = a[0] ? wd[7:0] : wd[15:8];
      erd  = 16'h0000;
      if (!mis && !hang && !wr) begin
         if (st)       erd = {8'h00, stat_lo};
         else if (byt) erd = {8'h00, ref_mem[idx]};
         else          erd = {ref_mem[idx], ref_mem[idx + 1]};
      end

      @(negedge clk);
      chk({nm, ".req_ready_idle"}, 32'(req_ready), 32'd1);
      req_addr  = a;
      req_write = wr;
      req_byte  = byt;
      req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;

      busy = 0; ncs = 0; nu = 0; nl = 0; nw = 0; first = 1'b1;
      seen_addr = '0; seen_dout = '0;
      while (!rsp_valid && busy <= 300) begin
         if (cs) begin
            ncs++;
            if (first) begin
               seen_addr = cpu_address;
               seen_dout = cpu_dout;
               first     = 1'b0;
            end
         end
         if (cpu_uds)          nu++;
         if (cpu_lds)          nl++;
         if (cpu_write_strobe) nw++;
         busy++;
         @(negedge clk);
      end
      chk({nm, ".rsp_arrived"}, 32'(rsp_valid), 32'd1);
      chk({nm, ".latency"}, 32'(busy), 32'(ecyc + (mis ? 0 : IC)));
      chk({nm, ".cs_cycles"}, 32'(ncs), 32'(ecyc));
      chk({nm, ".uds_cycles"}, 32'(nu), 32'((byt && a[0]) ? 0 : ecyc));
      chk({nm, ".lds_cycles"}, 32'(nl), 32'((byt && !a[0]) ? 0 : ecyc));
      chk({nm, ".we_cycles"}, 32'(nw), 32'(wr ? ecyc : 0));
      if (!mis)
         chk({nm, ".address"}, 32'(seen_addr), 32'(a[22:1]));
      if (!mis && wr)
         chk({nm, ".dout"}, 32'(seen_dout), 32'(byt ? {wb, wb} : wd));
      chk({nm, ".status"}, 32'(rsp_status), 32'(est));
      chk({nm, ".rdata"}, 32'(rsp_rdata), 32'(erd));
      chk({nm, ".bus_quiet"}, 32'({cs, cpu_uds, cpu_lds, cpu_write_strobe}), 32'd0);
      chk({nm, ".req_ready_busy"}, 32'(req_ready), 32'd0);

      if (wr && !mis && !hang) begin
         if (byt) ref_mem[idx] = wb;
         else begin
            ref_mem[idx]     = wd[15:8];
            ref_mem[idx + 1] = wd[7:0];
         end
      end

      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk({nm, ".rsp_held"}, 32'({rsp_valid, rsp_rdata}), 32'({1'b1, erd}));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({nm, ".rsp_dropped"}, 32'(rsp_valid), 32'd0);
      chk({nm, ".req_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int rsp_seen;
      reset_n   = 1'b0;
      ram_clr   = 1'b1;
      hang      = 1'b0;
      stat_lo   = 8'($urandom);
      req_valid = 1'b0;
      req_addr  = '0;
      req_write = 1'b0;
      req_byte  = 1'b0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;

      repeat (3) @(negedge clk);
      chk("reset.req_ready", 32'(req_ready), 32'd1);
      chk("reset.strobes", 32'({cs, cpu_uds, cpu_lds, cpu_write_strobe}), 32'd0);
      chk("reset.rsp", 32'({rsp_valid, rsp_status}), 32'd0);
      chk("reset.address", 32'(cpu_address), 32'd0);
      chk("reset.dout", 32'(cpu_dout), 32'd0);
      ram_clr = 1'b0;
      reset_n = 1'b1;

      // Word write then read-back through a one-wait-state RAM.
      txn("wr_word_100", 23'h000100, 1'b1, 1'b0, 16'h5AA5, 0);
      txn("rd_word_100", 23'h000100, 1'b0, 1'b0, 16'h0000, 2);

      // Byte lane write into a preloaded word.
      txn("wr_word_200", 23'h000200, 1'b1, 1'b0, 16'h1122, 0);
      txn("wr_byte_201", 23'h000201, 1'b1, 1'b1, 16'hA53C, 1);
      txn("rd_word_200", 23'h000200, 1'b0, 1'b0, 16'h0000, 0);
      txn("rd_byte_201", 23'h000201, 1'b0, 1'b1, 16'h0000, 0);
      txn("rd_byte_200", 23'h000200, 1'b0, 1'b1, 16'h0000, 0);

      // Zero-wait status register and misaligned word access.
      txn("rd_stat", 23'h4FFFF0, 1'b0, 1'b0, 16'h0000, 0);
      txn("rd_misaligned", 23'h000003, 1'b0, 1'b0, 16'h0000, 3);

      // Stuck responder: timeout, then a normal access.
      hang = 1'b1;
      txn("rd_timeout", 23'h000100, 1'b0, 1'b0, 16'h0000, 1);
      hang = 1'b0;
      txn("rd_after_timeout", 23'h000100, 1'b0, 1'b0, 16'h0000, 0);

      // Asynchronous reset in the middle of a waiting access.
      hang = 1'b1;
      @(negedge clk);
      req_addr  = 23'h000100;
      req_write = 1'b0;
      req_byte  = 1'b0;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid.in_wait", 32'(cs), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid.strobes", 32'({cs, cpu_uds, cpu_lds, cpu_write_strobe}), 32'd0);
      chk("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
      hang = 1'b0;
      @(negedge clk);
      reset_n  = 1'b1;
      rsp_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid || cs) rsp_seen++;
      end
      chk("rst_mid.no_response", 32'(rsp_seen), 32'd0);
      chk("rst_mid.req_ready", 32'(req_ready), 32'd1);
      txn("rd_after_reset", 23'h000100, 1'b0, 1'b0, 16'h0000, 0);

      // Randomized traffic against the reference memory.
      for (int n = 0; n < 40; n++) begin
         logic [22:0] ra;
         bit          rw, rb;
         if ($urandom_range(0, 9) == 0) begin
            ra = 23'h4FFFF0; rw = 1'b0; rb = 1'b0;
         end else begin
            ra = 23'($urandom_range(0, 2047));
            rw = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
         end
         txn($sformatf("rand%0d", n), ra, rw, rb, 16'($urandom), int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
